// File: rtl/int_sync_pkg.sv
// Shared constants and helpers for the interrupt sync crossing blocks.
package int_sync_pkg;

  localparam int SYNC_MAX   = 8;
  localparam int FILTER_MAX = 255;

  // Bits needed to count 0..n-1, never less than one so a counter always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/int_sync_chain.sv
// W-wide multi-flop synchronizer. Kept as its own module so CDC/timing
// constraints can target the chain flops directly; no logic between stages.
module int_sync_chain #(
  parameter int W    = 1,
  parameter int SYNC = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [SYNC];

  // Shift the asynchronous levels through SYNC flops; async active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC; k++) stage[k] <= '0;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < SYNC; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[SYNC-1];

endmodule

// File: rtl/int_sync_crossing_sink.sv
// Receiving end of the interrupt sync crossing: synchronize each line, apply an
// optional per-bit stability filter, and emit the level plus rise/fall pulses.
module int_sync_crossing_sink
  import int_sync_pkg::*;
#(
  parameter int W      = 1,
  parameter int SYNC   = 3,
  parameter int FILTER = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] auto_in_sync,
  output logic [W-1:0] auto_out,
  output logic [W-1:0] auto_out_rise,
  output logic [W-1:0] auto_out_fall
);

  localparam int             CNT_W    = clog2(FILTER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  logic [W-1:0]     s_p0;
  logic [CNT_W-1:0] cnt_p1 [W];
  logic [W-1:0]     update;

  // ---- stage p0: synchronized levels ----
  int_sync_chain #(
    .W    (W),
    .SYNC (SYNC)
  ) u_chain (
    .clock (clock),
    .reset (reset),
    .d     (auto_in_sync),
    .q     (s_p0)
  );

  // ---- stage p1: filter and edge pulses ----
  // A bit flips once its mismatch against auto_out has lasted FILTER samples.
  always_comb begin
    update = '0;
    for (int i = 0; i < W; i++) begin
      update[i] = (s_p0[i] != auto_out[i]) && (cnt_p1[i] == CNT_LAST);
    end
  end

  // Count consecutive mismatching samples; any agreement or a flip restarts at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < W; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if ((s_p0[i] == auto_out[i]) || update[i]) cnt_p1[i] <= '0;
        else                                       cnt_p1[i] <= cnt_p1[i] + 1'b1;
      end
    end
  end

  // Register the filtered level and a pulse marking the first cycle of a new value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_out      <= '0;
      auto_out_rise <= '0;
      auto_out_fall <= '0;
    end else begin
      auto_out      <= (auto_out & ~update) | (s_p0 & update);
      auto_out_rise <= update & s_p0;
      auto_out_fall <= update & ~s_p0;
    end
  end

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
`timescale 1ns/1ps
module tb_int_sync_crossing_sink;

  localparam int W    = 4;
  localparam int SYNC = 3;
  localparam int NDUT = 5;  // instances 0..3 use FILTER=1..4; instance 4 is FILTER=1 for random

  typedef struct {
    int           cyc;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n [NDUT];
  logic [W-1:0] din   [NDUT];
  logic [W-1:0] dout  [NDUT];
  logic [W-1:0] drise [NDUT];
  logic [W-1:0] dfall [NDUT];

  ev_t          exp_q [NDUT][$];
  logic [W-1:0] hist  [$];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  bit           rnd_on = 1'b0;
  logic [W-1:0] prev_out4 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int g, input int c, input logic [W-1:0] o,
                      input logic [W-1:0] r, input logic [W-1:0] f);
    ev_t e;
    e.cyc  = c;
    e.out  = o;
    e.rise = r;
    e.fall = f;
    exp_q[g].push_back(e);
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int F = (g == NDUT - 1) ? 1 : g + 1;

    int_sync_crossing_sink #(
      .W      (W),
      .SYNC   (SYNC),
      .FILTER (F)
    ) u_dut (
      .clock         (clk),
      .reset         (rst_n[g]),
      .auto_in_sync  (din[g]),
      .auto_out      (dout[g]),
      .auto_out_rise (drise[g]),
      .auto_out_fall (dfall[g])
    );

    if (g < NDUT - 1) begin : g_mon
      ev_t e;
      // Whenever a pulse appears, pop the next expected event and compare it.
      always @(negedge clk) begin
        if ((drise[g] | dfall[g]) != '0) begin
          chk($sformatf("dut%0d_overlap", g), 32'(drise[g] & dfall[g]), 32'd0);
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_pulse at cycle %0d: rise %b fall %b expected none",
                     g, cyc, drise[g], dfall[g]);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("dut%0d_ev_cycle", g), 32'(cyc), 32'(e.cyc));
            chk($sformatf("dut%0d_ev_out", g), 32'(dout[g]), 32'(e.out));
            chk($sformatf("dut%0d_ev_rise", g), 32'(drise[g]), 32'(e.rise));
            chk($sformatf("dut%0d_ev_fall", g), 32'(dfall[g]), 32'(e.fall));
          end
        end
      end
    end
  end

  // Record what the source presented at each local edge during the random phase.
  always @(posedge clk) begin
    if (rnd_on) hist.push_back(din[NDUT-1]);
  end

  // Random-phase monitor: output tracks input lagged ~SYNC+FILTER, pulses mark transitions.
  always @(negedge clk) begin
    if (rnd_on && hist.size() >= 6) begin
      logic ok;
      int   n;
      ok = 1'b1;
      n  = hist.size();
      for (int i = 0; i < W; i++) begin
        if (dout[NDUT-1][i] !== hist[n-3][i] && dout[NDUT-1][i] !== hist[n-4][i] &&
            dout[NDUT-1][i] !== hist[n-5][i]) ok = 1'b0;
      end
      chk("rnd_lag", 32'(ok), 32'd1);
      chk("rnd_rise", 32'(drise[NDUT-1]), 32'(dout[NDUT-1] & ~prev_out4));
      chk("rnd_fall", 32'(dfall[NDUT-1]), 32'(~dout[NDUT-1] & prev_out4));
    end
    prev_out4 <= dout[NDUT-1];
  end

  initial begin
    int e0;
    for (int g = 0; g < NDUT; g++) begin
      rst_n[g] = 1'b0;
      din[g]   = '0;
    end
    din[0] = 4'hF;

    // Test 1: outputs stay clear while reset is held, then rise after SYNC+FILTER edges
    repeat (3) @(negedge clk);
    chk("rst_hold_out", 32'(dout[0]), 32'd0);
    chk("rst_hold_rise", 32'(drise[0]), 32'd0);
    chk("rst_hold_fall", 32'(dfall[0]), 32'd0);
    e0 = cyc;
    for (int g = 0; g < NDUT; g++) rst_n[g] = 1'b1;
    push(0, e0 + 4, 4'hF, 4'hF, 4'h0);
    repeat (5) @(negedge clk);
    chk("t1_out_held", 32'(dout[0]), 32'hF);
    chk("t1_rise_single", 32'(drise[0]), 32'd0);

    // Test 2 (FILTER=2): one-cycle glitch discarded, two-cycle pulse passes
    din[1] = 4'b0001;
    @(negedge clk);
    din[1] = 4'b0000;
    repeat (10) @(negedge clk);
    chk("t2_glitch_out", 32'(dout[1]), 32'd0);
    e0 = cyc;
    din[1] = 4'b0001;
    push(1, e0 + 5, 4'b0001, 4'b0001, 4'b0000);
    push(1, e0 + 7, 4'b0000, 4'b0000, 4'b0001);
    repeat (2) @(negedge clk);
    din[1] = 4'b0000;
    repeat (10) @(negedge clk);
    chk("t2_final_out", 32'(dout[1]), 32'd0);

    // Test 3 (FILTER=4): interrupted run restarts the count
    e0 = cyc;
    din[3] = 4'b0010;
    repeat (3) @(negedge clk);
    din[3] = 4'b0000;
    @(negedge clk);
    din[3] = 4'b0010;
    push(3, e0 + 11, 4'b0010, 4'b0010, 4'b0000);
    repeat (6) @(negedge clk);
    chk("t3_not_yet", 32'(dout[3]), 32'd0);
    repeat (8) @(negedge clk);
    chk("t3_final_out", 32'(dout[3]), 32'b0010);

    // Test 4 (FILTER=1): simultaneous rises and fall on the same cycle
    e0 = cyc;
    din[0] = 4'b1010;
    push(0, e0 + 4, 4'b1010, 4'b0000, 4'b0101);
    repeat (6) @(negedge clk);
    e0 = cyc;
    din[0] = 4'b0111;
    push(0, e0 + 4, 4'b0111, 4'b0101, 4'b1000);
    repeat (6) @(negedge clk);
    chk("t4_final_out", 32'(dout[0]), 32'b0111);

    // Test 5 (FILTER=3): reset mid-count clears asynchronously, input reappears later
    e0 = cyc;
    din[2] = 4'b0010;
    push(2, e0 + 6, 4'b0010, 4'b0010, 4'b0000);
    repeat (8) @(negedge clk);
    e0 = cyc;
    din[2] = 4'b0011;
    repeat (4) @(negedge clk);
    #1 rst_n[2] = 1'b0;
    #1;
    chk("t5_async_out", 32'(dout[2]), 32'd0);
    chk("t5_async_rise", 32'(drise[2]), 32'd0);
    chk("t5_async_fall", 32'(dfall[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    e0 = cyc;
    push(2, e0 + 6, 4'b0011, 4'b0011, 4'b0000);
    repeat (9) @(negedge clk);
    chk("t5_final_out", 32'(dout[2]), 32'b0011);

    // Test 6: jittered source ticking at ~1.7x the local clock
    rnd_on = 1'b1;
    repeat (600) begin
      #($urandom_range(500, 676) / 100.0);
      din[NDUT-1] = din[NDUT-1] ^ 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rnd_on = 1'b0;

    repeat (10) @(negedge clk);
    for (int g = 0; g < NDUT - 1; g++) begin
      chk($sformatf("dut%0d_queue_drained", g), 32'(exp_q[g].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
